apb_pwm_ctrl: RTL and testbench

APB_PWM_CTRL -- requirements
Module: apb_pwm_ctrl

---
 rtl/apb_pwm_ctrl_if.sv | 21 ++
 rtl/apb_pwm_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_apb_pwm_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pwm_ctrl_if.sv
// APB slave bus bundle for apb_pwm_ctrl: the master drives requests, the slave returns data and status.
interface apb_pwm_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_pwm_ctrl.sv
// APB-programmable PWM generator with shadowed PERIOD/DUTY registers and a sticky WRAP flag.
// Defining APB_PWM_IRQ_EN adds the PWM_IRQ output and makes CTRL.IE writable.
module apb_pwm_ctrl #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic          PCLK,
  input  logic          PRESET,
  apb_pwm_ctrl_if.slave apb,
`ifdef APB_PWM_IRQ_EN
  output logic          PWM_IRQ,
`endif
  output logic          PWM_OUT
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_DUTY   = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  reg_sel_e sel;

  logic wr_acc;
  logic wr_ctrl;
  logic wr_period;
  logic wr_duty;
  logic wr_status;
  logic wrap_clr;
  logic en_rise;
  logic at_end;
  logic load_act;

  logic en_q, en_d;
  logic pol_q, pol_d;
  logic ie_q, ie_d;
  logic wrap_q, wrap_d;
  logic pwm_q, pwm_d;

  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] duty_q, duty_d;
  logic [CNT_WIDTH-1:0] period_a_q, period_a_d;
  logic [CNT_WIDTH-1:0] duty_a_q, duty_a_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [31:0] rdata;
  logic        unused_bits;

  assign sel       = reg_sel_e'(apb.PADDR[3:2]);
  assign wr_acc    = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign wr_ctrl   = wr_acc & (sel == REG_CTRL);
  assign wr_period = wr_acc & (sel == REG_PERIOD);
  assign wr_duty   = wr_acc & (sel == REG_DUTY);
  assign wr_status = wr_acc & (sel == REG_STATUS);
  assign wrap_clr  = wr_status & apb.PWDATA[31];

  assign unused_bits = ^{apb.PADDR[11:4], apb.PADDR[1:0], apb.PWDATA};

  assign apb.PREADY  = 1'b1;
  // STATUS is read-only apart from the W1C of WRAP; any other write to it errors.
  assign apb.PSLVERR = wr_status & ~apb.PWDATA[31] & ~PRESET;

  assign en_rise  = wr_ctrl & apb.PWDATA[0] & ~en_q;
  assign at_end   = en_q & (cnt_q == period_a_q);
  assign load_act = at_end | en_rise;

  always_comb begin : ctrl_next
    en_d  = en_q;
    pol_d = pol_q;
    ie_d  = ie_q;
    if (wr_ctrl) begin
      en_d  = apb.PWDATA[0];
      pol_d = apb.PWDATA[1];
`ifdef APB_PWM_IRQ_EN
      ie_d  = apb.PWDATA[2];
`else
      ie_d  = 1'b0;
`endif
    end
  end

  // Shadow next-values feed the active copies so a write landing on a wrap takes effect at once.
  always_comb begin : shadow_next
    period_d = period_q;
    duty_d   = duty_q;
    if (wr_period) begin
      period_d = apb.PWDATA[CNT_WIDTH-1:0];
    end
    if (wr_duty) begin
      duty_d = apb.PWDATA[CNT_WIDTH-1:0];
    end
  end

  always_comb begin : active_next
    period_a_d = period_a_q;
    duty_a_d   = duty_a_q;
    if (load_act) begin
      period_a_d = period_d;
      duty_a_d   = duty_d;
    end
  end

  always_comb begin : counter_next
    cnt_d = cnt_q + CNT_WIDTH'(1);
    if (!en_q || !en_d || at_end) begin
      cnt_d = '0;
    end
  end

  // Set beats clear when a wrap and a W1C land on the same edge.
  always_comb begin : wrap_next
    wrap_d = wrap_q;
    if (wrap_clr) begin
      wrap_d = 1'b0;
    end
    if (at_end) begin
      wrap_d = 1'b1;
    end
  end

  assign pwm_d = pol_q ^ (en_q & (cnt_q < duty_a_q));

  always_comb begin : read_mux
    rdata = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (sel)
        REG_CTRL: begin
          rdata[0] = en_q;
          rdata[1] = pol_q;
          rdata[2] = ie_q;
        end
        REG_PERIOD: rdata[CNT_WIDTH-1:0] = period_q;
        REG_DUTY:   rdata[CNT_WIDTH-1:0] = duty_q;
        REG_STATUS: begin
          rdata[CNT_WIDTH-1:0] = cnt_q;
          rdata[31]            = wrap_q;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA = rdata;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q       <= 1'b0;
      pol_q      <= 1'b0;
      ie_q       <= 1'b0;
      period_q   <= '0;
      duty_q     <= '0;
      period_a_q <= '0;
      duty_a_q   <= '0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      pol_q      <= pol_d;
      ie_q       <= ie_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      period_a_q <= period_a_d;
      duty_a_q   <= duty_a_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      pwm_q      <= pwm_d;
    end
  end

  assign PWM_OUT = pwm_q;

`ifdef APB_PWM_IRQ_EN
  logic irq_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ie_q & wrap_q;
    end
  end

  assign PWM_IRQ = irq_q;
`endif

endmodule

// File: tb/tb_apb_pwm_ctrl.sv
// Directed testbench for apb_pwm_ctrl; IRQ scenarios are included when APB_PWM_IRQ_EN is defined.
module tb_apb_pwm_ctrl;

  logic PCLK = 1'b0;
  logic PRESET;
  logic pwm_out;
`ifdef APB_PWM_IRQ_EN
  logic pwm_irq;
  localparam logic [31:0] CTRL_ALL = 32'h7;
  localparam logic [31:0] CTRL_RUN = 32'h5;
`else
  localparam logic [31:0] CTRL_ALL = 32'h3;
  localparam logic [31:0] CTRL_RUN = 32'h1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  apb_pwm_ctrl_if bus ();

  apb_pwm_ctrl #(.CNT_WIDTH(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (bus),
`ifdef APB_PWM_IRQ_EN
    .PWM_IRQ(pwm_irq),
`endif
    .PWM_OUT(pwm_out)
  );

  always #5 PCLK = ~PCLK;

  // All bus tasks start and end 1ns after a rising edge; a write commits on the second edge.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #1 err = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = a;
    #1 d = bus.PRDATA;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    PRESET      = 1'b1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 12'hC;
    bus.PWDATA  = 32'h0;
    #12;
    n_checks++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
    n_checks++;
    if (bus.PREADY !== 1'b1) begin n_fail++; $display("FAIL reset_pready: got %b expected 1", bus.PREADY); end
    n_checks++;
    if (bus.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b expected 0", bus.PSLVERR); end
`ifdef APB_PWM_IRQ_EN
    n_checks++;
    if (pwm_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", pwm_irq); end
`endif
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apb_read(12'(i * 4), rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 00000000", i, rd); end
    end
  endtask

  task automatic test_registers();
    logic [31:0] rd;
    logic        err;
    apb_write(12'h4, 32'hFFFF_FFFF, err);
    apb_read(12'h4, rd);
    n_checks++;
    if (rd !== 32'h0000_FFFF) begin n_fail++; $display("FAIL period_width: got %h expected 0000ffff", rd); end
    apb_write(12'h4, 32'd9, err);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL period_slverr: got %b expected 0", err); end
    apb_write(12'h8, 32'd3, err);
    apb_read(12'h8, rd);
    n_checks++;
    if (rd !== 32'd3) begin n_fail++; $display("FAIL duty_rb: got %h expected 00000003", rd); end
    // Setup phase only: must not commit and must not drive read data.
    bus.PSEL   = 1'b1;
    bus.PWRITE = 1'b1;
    bus.PADDR  = 12'h8;
    bus.PWDATA = 32'd5;
    #1;
    n_checks++;
    if (bus.PRDATA !== 32'h0) begin n_fail++; $display("FAIL prdata_on_write: got %h expected 00000000", bus.PRDATA); end
    @(posedge PCLK); #1;
    bus.PSEL   = 1'b0;
    bus.PWRITE = 1'b0;
    bus.PADDR  = 12'h4;
    #1;
    n_checks++;
    if (bus.PRDATA !== 32'h0) begin n_fail++; $display("FAIL prdata_unselected: got %h expected 00000000", bus.PRDATA); end
    apb_read(12'h8, rd);
    n_checks++;
    if (rd !== 32'd3) begin n_fail++; $display("FAIL setup_only_write: got %h expected 00000003", rd); end
    apb_write(12'h0, 32'hFFFF_FFFF, err);
    apb_read(12'h0, rd);
    n_checks++;
    if (rd !== CTRL_ALL) begin n_fail++; $display("FAIL ctrl_rb: got %h expected %h", rd, CTRL_ALL); end
    apb_write(12'h0, 32'h0, err);
  endtask

  task automatic test_basic_pwm();
    logic        err;
    logic        exp;
    logic [31:0] rd;
    apb_write(12'h0, 32'h1, err);
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) begin @(posedge PCLK); #1; end
      exp = (k >= 1) && (((k - 1) % 10) < 3);
      n_checks++;
      if (pwm_out !== exp) begin n_fail++; $display("FAIL basic_pwm k=%0d: got %b expected %b", k, pwm_out, exp); end
    end
    apb_write(12'h0, 32'h0, err);
    @(posedge PCLK); #1;
    n_checks++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL disable_pwm: got %b expected 0", pwm_out); end
    apb_read(12'hC, rd);
    n_checks++;
    if (rd !== 32'h8000_0000) begin n_fail++; $display("FAIL disable_status: got %h expected 80000000", rd); end
  endtask

  task automatic test_polarity();
    logic err;
    logic exp;
    apb_write(12'h0, 32'h3, err);
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) begin @(posedge PCLK); #1; end
      exp = (k >= 1) && !(((k - 1) % 10) < 3);
      n_checks++;
      if (pwm_out !== exp) begin n_fail++; $display("FAIL pol_pwm k=%0d: got %b expected %b", k, pwm_out, exp); end
    end
    apb_write(12'h0, 32'h2, err);
    for (int k = 0; k < 5; k++) begin
      @(posedge PCLK); #1;
      n_checks++;
      if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL pol_idle k=%0d: got %b expected 1", k, pwm_out); end
    end
    apb_write(12'h0, 32'h0, err);
  endtask

  task automatic test_duty_update();
    logic err;
    logic exp;
    int   duty;
    apb_write(12'h0, 32'h1, err);
    apb_write(12'h8, 32'd7, err);
    for (int k = 2; k <= 30; k++) begin
      if (k > 2) begin @(posedge PCLK); #1; end
      duty = ((k - 1) / 10 == 0) ? 3 : 7;
      exp  = ((k - 1) % 10) < duty;
      n_checks++;
      if (pwm_out !== exp) begin n_fail++; $display("FAIL duty_update k=%0d: got %b expected %b", k, pwm_out, exp); end
    end
    apb_write(12'h0, 32'h0, err);
  endtask

  task automatic test_boundaries();
    logic err;
    apb_write(12'h8, 32'd12, err);
    apb_write(12'h0, 32'h1, err);
    for (int k = 1; k <= 25; k++) begin
      @(posedge PCLK); #1;
      n_checks++;
      if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL duty_over k=%0d: got %b expected 1", k, pwm_out); end
    end
    apb_write(12'h0, 32'h0, err);
    apb_write(12'h4, 32'd0, err);
    apb_write(12'h8, 32'd1, err);
    apb_write(12'h0, 32'h1, err);
    for (int k = 1; k <= 10; k++) begin
      @(posedge PCLK); #1;
      n_checks++;
      if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL p0_d1 k=%0d: got %b expected 1", k, pwm_out); end
    end
    apb_write(12'h0, 32'h0, err);
    apb_write(12'h8, 32'd0, err);
    apb_write(12'h0, 32'h1, err);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin @(posedge PCLK); #1; end
      n_checks++;
      if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL p0_d0 k=%0d: got %b expected 0", k, pwm_out); end
    end
    // Wrap every cycle: a DUTY write must reach the active copy on its own commit edge.
    apb_write(12'h8, 32'd1, err);
    n_checks++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL wrap_load_k0: got %b expected 0", pwm_out); end
    @(posedge PCLK); #1;
    n_checks++;
    if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL wrap_load_k1: got %b expected 1", pwm_out); end
    apb_write(12'h0, 32'h0, err);
  endtask

  task automatic test_status();
    logic        err;
    logic [31:0] rd;
    apb_read(12'hC, rd);
    n_checks++;
    if (rd !== 32'h8000_0000) begin n_fail++; $display("FAIL status_idle: got %h expected 80000000", rd); end
    apb_write(12'hC, 32'h0, err);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL status_wr_err: got %b expected 1", err); end
    apb_read(12'hC, rd);
    n_checks++;
    if (rd !== 32'h8000_0000) begin n_fail++; $display("FAIL status_kept: got %h expected 80000000", rd); end
    apb_write(12'hC, 32'h8000_0000, err);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL w1c_err: got %b expected 0", err); end
    apb_read(12'hC, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h expected 00000000", rd); end
    apb_write(12'h0, 32'h1, err);
    apb_write(12'hC, 32'h8000_0000, err);
    bus.PSEL    = 1'b1;
    bus.PWRITE  = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PADDR   = 12'hC;
    #1;
    n_checks++;
    if (bus.PRDATA !== 32'h8000_0000) begin n_fail++; $display("FAIL w1c_vs_wrap: got %h expected 80000000", bus.PRDATA); end
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0;
    apb_write(12'h0, 32'h0, err);
  endtask

`ifdef APB_PWM_IRQ_EN
  task automatic test_irq();
    logic err;
    logic exp_wrap;
    logic exp_irq;
    apb_write(12'hC, 32'h8000_0000, err);
    apb_write(12'h4, 32'd9, err);
    apb_write(12'h8, 32'd3, err);
    apb_write(12'h0, 32'h5, err);
    bus.PSEL   = 1'b1;
    bus.PWRITE = 1'b0;
    bus.PADDR  = 12'hC;
    #1;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) begin @(posedge PCLK); #2; end
      exp_wrap = (k >= 10);
      exp_irq  = (k >= 11);
      n_checks++;
      if (bus.PRDATA[31] !== exp_wrap) begin n_fail++; $display("FAIL irq_wrap k=%0d: got %b expected %b", k, bus.PRDATA[31], exp_wrap); end
      n_checks++;
      if (pwm_irq !== exp_irq) begin n_fail++; $display("FAIL irq_out k=%0d: got %b expected %b", k, pwm_irq, exp_irq); end
    end
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic        err;
    logic [31:0] rd;
    apb_write(12'h0, 32'h0, err);
    apb_write(12'h4, 32'd9, err);
    apb_write(12'h8, 32'd3, err);
    apb_write(12'h0, CTRL_RUN, err);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    n_checks++;
    if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pwm: got %b expected 1", pwm_out); end
`ifdef APB_PWM_IRQ_EN
    n_checks++;
    if (pwm_irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", pwm_irq); end
`endif
    #2 PRESET = 1'b1;
    #1;
    n_checks++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pwm: got %b expected 0", pwm_out); end
`ifdef APB_PWM_IRQ_EN
    n_checks++;
    if (pwm_irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: got %b expected 0", pwm_irq); end
`endif
    n_checks++;
    if (bus.PREADY !== 1'b1 || bus.PSLVERR !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_resp: got %b%b expected 10", bus.PREADY, bus.PSLVERR);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge PCLK); #1;
      n_checks++;
      if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL post_reset_pwm k=%0d: got %b expected 0", k, pwm_out); end
    end
    apb_read(12'h0, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL post_reset_ctrl: got %h expected 00000000", rd); end
    apb_read(12'hC, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL post_reset_status: got %h expected 00000000", rd); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    test_reset();
    test_registers();
    test_basic_pwm();
    test_polarity();
    test_duty_update();
    test_boundaries();
    test_status();
`ifdef APB_PWM_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
